uart_bus_master: RTL and testbench

UART_BUS_MASTER -- requirements
Module: uart_bus_master

---
 rtl/uart_bus_master_pkg.sv | 10 +
 rtl/uart_byte_rx.sv | 84 ++++++++
 rtl/uart_bus_master.sv | 146 ++++++++++++++
 tb/tb_uart_bus_master.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/uart_bus_master_pkg.sv
// Shared constants for the UART bus master and the host-side code that talks to it.
package uart_bus_master_pkg;
  localparam logic [7:0] OP_WRITE = 8'hA5;
  localparam logic [7:0] OP_READ  = 8'h5A;
  localparam logic [7:0] RSP_OK   = 8'h4B;
  localparam logic [7:0] RSP_ERR  = 8'h45;

  typedef enum logic [2:0] {P_IDLE, P_ADDR, P_DATA, P_EXEC, P_RESP} pstate_e;
  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rstate_e;
endpackage

// File: rtl/uart_byte_rx.sv
// 8N1 byte receiver: 2-flop synchronizer, mid-bit sampling, stop-bit check.
module uart_byte_rx
  import uart_bus_master_pkg::*;
#(
  parameter int DIVISOR = 434
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       rxd_i,
  output logic [7:0] byte_o,
  output logic       vld_o,
  output logic       err_o
);
  localparam int CW = $clog2(DIVISOR);

  logic [1:0]    sync_q;
  logic          prev_q, rx;
  rstate_e       st_q, st_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    sh_q, sh_d;
  logic          vld_q, vld_d, err_q, err_d;

  assign rx     = sync_q[1];
  assign byte_o = sh_q;
  assign vld_o  = vld_q;
  assign err_o  = err_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      st_q   <= R_IDLE;
      cnt_q  <= '0;
      bit_q  <= '0;
      sh_q   <= '0;
      vld_q  <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], rxd_i};
      prev_q <= rx;
      st_q   <= st_d;
      cnt_q  <= cnt_d;
      bit_q  <= bit_d;
      sh_q   <= sh_d;
      vld_q  <= vld_d;
      err_q  <= err_d;
    end
  end

  always_comb begin
    st_d  = st_q;
    cnt_d = cnt_q + CW'(1);
    bit_d = bit_q;
    sh_d  = sh_q;
    vld_d = 1'b0;
    err_d = 1'b0;
    case (st_q)
      R_IDLE: begin
        cnt_d = '0;
        if (prev_q && !rx) st_d = R_START;
      end
      // A line that is high again at mid start bit was only a glitch.
      R_START: if (cnt_q == CW'(DIVISOR/2 - 1)) begin
        cnt_d = '0;
        bit_d = '0;
        st_d  = rx ? R_IDLE : R_DATA;
      end
      R_DATA: if (cnt_q == CW'(DIVISOR - 1)) begin
        cnt_d = '0;
        sh_d  = {rx, sh_q[7:1]};
        if (bit_q == 3'd7) st_d = R_STOP;
        else               bit_d = bit_q + 3'd1;
      end
      R_STOP: if (cnt_q == CW'(DIVISOR - 1)) begin
        cnt_d = '0;
        st_d  = R_IDLE;
        vld_d = rx;
        err_d = !rx;
      end
      default: st_d = R_IDLE;
    endcase
  end
endmodule

// File: rtl/uart_bus_master.sv
// UART command parser driving a single-beat bus initiator, with serial responses.
module uart_bus_master
  import uart_bus_master_pkg::*;
#(
  parameter int DIVISOR = 434,
  parameter int TIMEOUT = 500000
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        uart_rxd,
  output logic        uart_txd,
  output logic [31:0] m_addr,
  output logic [31:0] m_wd,
  output logic        m_we,
  output logic        m_re,
  input  logic [31:0] m_rd,
  output logic        busy,
  output logic        frame_err
);
  localparam int CW = $clog2(DIVISOR);
  localparam int TW = $clog2(TIMEOUT + 1);

  logic [7:0]    rx_byte;
  logic          rx_vld, rx_err;
  pstate_e       st_q, st_d;
  logic          rd_q, rd_d, we_q, we_d, re_q, re_d, ferr_q, ferr_d;
  logic [1:0]    bc_q, bc_d;
  logic [31:0]   addr_q, addr_d, wd_q, wd_d, rsp_q, rsp_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [2:0]    rn_q, rn_d;
  logic [9:0]    fr_q, fr_d;
  logic [3:0]    tb_q, tb_d;
  logic [CW-1:0] tc_q, tc_d;
  logic          ta_q, ta_d, tx_end, tx_load;

  uart_byte_rx #(.DIVISOR(DIVISOR)) u_rx (
    .clk(clk), .rstn(rstn), .rxd_i(uart_rxd),
    .byte_o(rx_byte), .vld_o(rx_vld), .err_o(rx_err)
  );

  assign uart_txd  = fr_q[0];
  assign m_addr    = addr_q;
  assign m_wd      = wd_q;
  assign m_we      = we_q;
  assign m_re      = re_q;
  assign frame_err = ferr_q;
  assign busy      = (st_q != P_IDLE);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      st_q <= P_IDLE; rd_q <= 1'b0; we_q <= 1'b0; re_q <= 1'b0; ferr_q <= 1'b0;
      bc_q <= '0; addr_q <= '0; wd_q <= '0; rsp_q <= '0; tmo_q <= '0; rn_q <= '0;
      fr_q <= '1; tb_q <= '0; tc_q <= '0; ta_q <= 1'b0;
    end else begin
      st_q <= st_d; rd_q <= rd_d; we_q <= we_d; re_q <= re_d; ferr_q <= ferr_d;
      bc_q <= bc_d; addr_q <= addr_d; wd_q <= wd_d; rsp_q <= rsp_d; tmo_q <= tmo_d; rn_q <= rn_d;
      fr_q <= fr_d; tb_q <= tb_d; tc_q <= tc_d; ta_q <= ta_d;
    end
  end

  always_comb begin
    st_d = st_q; rd_d = rd_q; bc_d = bc_q; addr_d = addr_q; wd_d = wd_q;
    rsp_d = rsp_q; rn_d = rn_q; fr_d = fr_q; tb_d = tb_q; tc_d = tc_q; ta_d = ta_q;
    we_d = 1'b0; re_d = 1'b0; ferr_d = 1'b0; tmo_d = '0;

    // Transmitter: the next queued byte loads in the last stop-bit cycle, so no idle gap.
    tx_end  = ta_q && (tc_q == CW'(DIVISOR - 1)) && (tb_q == 4'd9);
    tx_load = (rn_q != 3'd0) && (!ta_q || tx_end);
    if (tx_load) begin
      fr_d  = {1'b1, rsp_q[31:24], 1'b0};
      ta_d  = 1'b1;
      tc_d  = '0;
      tb_d  = '0;
      rsp_d = {rsp_q[23:0], 8'h00};
      rn_d  = rn_q - 3'd1;
    end else if (ta_q) begin
      if (tc_q == CW'(DIVISOR - 1)) begin
        tc_d = '0;
        if (tb_q == 4'd9) begin
          ta_d = 1'b0;
          fr_d = '1;
        end else begin
          tb_d = tb_q + 4'd1;
          fr_d = {1'b1, fr_q[9:1]};
        end
      end else begin
        tc_d = tc_q + CW'(1);
      end
    end

    case (st_q)
      P_IDLE: begin
        if (rx_err) begin
          ferr_d = 1'b1;
        end else if (rx_vld) begin
          if (rx_byte == OP_WRITE || rx_byte == OP_READ) begin
            st_d   = P_ADDR;
            rd_d   = (rx_byte == OP_READ);
            bc_d   = '0;
            addr_d = '0;
            wd_d   = '0;
          end else begin
            ferr_d = 1'b1;
            rsp_d  = {RSP_ERR, 24'h0};
            rn_d   = 3'd1;
            st_d   = P_RESP;
          end
        end
      end
      P_ADDR, P_DATA: begin
        if (rx_err) begin
          ferr_d = 1'b1;
          st_d   = P_IDLE;
        end else if (rx_vld) begin
          if (st_q == P_ADDR) addr_d = {addr_q[23:0], rx_byte};
          else                wd_d   = {wd_q[23:0], rx_byte};
          if (bc_q == 2'd3) begin
            bc_d = '0;
            if (st_q == P_DATA || rd_q) begin
              st_d = P_EXEC;
              we_d = !rd_q;
              re_d = rd_q;
            end else begin
              st_d = P_DATA;
            end
          end else begin
            bc_d = bc_q + 2'd1;
          end
        end else if (tmo_q == TW'(TIMEOUT - 1)) begin
          ferr_d = 1'b1;
          st_d   = P_IDLE;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      // Strobe is high this cycle; read data is captured at its closing edge.
      P_EXEC: begin
        st_d  = P_RESP;
        rsp_d = rd_q ? m_rd : {RSP_OK, 24'h0};
        rn_d  = rd_q ? 3'd4 : 3'd1;
      end
      P_RESP: if (tx_end && rn_q == 3'd0) st_d = P_IDLE;
      default: st_d = P_IDLE;
    endcase
  end
endmodule

// File: tb/tb_uart_bus_master.sv
// Directed bench: table of command frames plus timeout, framing, glitch and reset sequences.
module tb_uart_bus_master;
  localparam int DIV = 16;
  localparam int TMO = 2000;

  logic        clk = 1'b0, rstn = 1'b0, uart_rxd = 1'b1;
  logic        uart_txd, m_we, m_re, busy, frame_err;
  logic [31:0] m_addr, m_wd, m_rd = 32'h0;

  uart_bus_master #(.DIVISOR(DIV), .TIMEOUT(TMO)) dut (
    .clk(clk), .rstn(rstn), .uart_rxd(uart_rxd), .uart_txd(uart_txd),
    .m_addr(m_addr), .m_wd(m_wd), .m_we(m_we), .m_re(m_re), .m_rd(m_rd),
    .busy(busy), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  int we_cnt, re_cnt, err_cnt, both_cnt;
  logic [31:0] cap_addr, cap_wd;
  logic [7:0]  rxq[$];

  always @(negedge clk) begin
    if (m_we) begin we_cnt++; cap_addr = m_addr; cap_wd = m_wd; end
    if (m_re) begin re_cnt++; cap_addr = m_addr; cap_wd = m_wd; end
    if (m_we && m_re) both_cnt++;
    if (frame_err) err_cnt++;
  end

  initial begin : tx_mon
    logic [7:0] b;
    forever begin
      @(negedge uart_txd);
      repeat (DIV/2) @(negedge clk);
      b = 8'h00;
      for (int i = 0; i < 8; i++) begin
        repeat (DIV) @(negedge clk);
        b[i] = uart_txd;
      end
      repeat (DIV) @(negedge clk);
      rxq.push_back(b);
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    @(negedge clk);
    uart_rxd = 1'b0;
    repeat (DIV) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rxd = b[i];
      repeat (DIV) @(negedge clk);
    end
    uart_rxd = stop;
    repeat (DIV) @(negedge clk);
    uart_rxd = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic clear_mon();
    we_cnt = 0; re_cnt = 0; err_cnt = 0; both_cnt = 0;
    cap_addr = 32'hx; cap_wd = 32'hx;
    rxq.delete();
  endtask

  typedef struct {
    string       name;
    logic [71:0] bytes;   // first byte in [71:64]
    int          n;
    logic [31:0] rd;
    int          we, re;
    logic [31:0] addr, wd;
    int          nrsp;
    logic [31:0] rsp;     // first response byte in [31:24]
    int          nerr;
  } vec_t;

  vec_t vt[5];

  task automatic apply_vec(input vec_t v);
    logic [7:0] got;
    clear_mon();
    m_rd = v.rd;
    for (int i = 0; i < v.n; i++) send_byte(v.bytes[71-8*i -: 8], 1'b1);
    repeat (900) @(negedge clk);
    chk({v.name, " we"},   we_cnt, v.we);
    chk({v.name, " re"},   re_cnt, v.re);
    chk({v.name, " both"}, both_cnt, 0);
    chk({v.name, " err"},  err_cnt, v.nerr);
    if (v.we + v.re > 0) begin
      chk({v.name, " addr"}, cap_addr, v.addr);
      chk({v.name, " wd"},   cap_wd, v.wd);
    end
    chk({v.name, " nrsp"}, rxq.size(), v.nrsp);
    for (int i = 0; i < v.nrsp; i++) begin
      got = (i < rxq.size()) ? rxq[i] : 8'hxx;
      chk({v.name, " rsp byte"}, {24'h0, got}, {24'h0, v.rsp[31-8*i -: 8]});
    end
    chk({v.name, " busy end"}, busy, 1'b0);
  endtask

  initial begin
    int lows;
    vt[0] = '{"write", 72'hA5_00007F10_12345678, 9, 32'h0, 1, 0, 32'h00007F10, 32'h12345678, 1, 32'h4B000000, 0};
    vt[1] = '{"read",  72'h5A_00007F20_00000000, 5, 32'hDEADBEEF, 0, 1, 32'h00007F20, 32'h0, 4, 32'hDEADBEEF, 0};
    vt[2] = '{"badop", 72'h33_00000000_00000000, 1, 32'h0, 0, 0, 32'h0, 32'h0, 1, 32'h45000000, 1};
    vt[3] = '{"wr_ones", 72'hA5_FFFFFFFF_00000000, 9, 32'h0, 1, 0, 32'hFFFFFFFF, 32'h0, 1, 32'h4B000000, 0};
    vt[4] = '{"rd_zero", 72'h5A_00000000_00000000, 5, 32'h00000001, 0, 1, 32'h0, 32'h0, 4, 32'h00000001, 0};

    clear_mon();
    repeat (3) @(negedge clk);
    chk("rst txd", uart_txd, 1'b1);
    chk("rst we", m_we, 1'b0);
    chk("rst re", m_re, 1'b0);
    chk("rst addr", m_addr, 32'h0);
    chk("rst wd", m_wd, 32'h0);
    chk("rst busy", busy, 1'b0);
    chk("rst ferr", frame_err, 1'b0);
    rstn = 1'b1;
    repeat (5) @(negedge clk);

    foreach (vt[i]) apply_vec(vt[i]);

    // Timeout mid-frame, then a good frame afterwards
    clear_mon();
    send_byte(8'hA5, 1'b1); send_byte(8'h00, 1'b1); send_byte(8'h00, 1'b1);
    chk("tmo busy during", busy, 1'b1);
    repeat (1900) @(negedge clk);
    chk("tmo early err", err_cnt, 0);
    repeat (200) @(negedge clk);
    chk("tmo err", err_cnt, 1);
    chk("tmo busy", busy, 1'b0);
    chk("tmo bus", we_cnt + re_cnt, 0);
    repeat (200) @(negedge clk);
    chk("tmo rsp", rxq.size(), 0);
    apply_vec(vt[0]);

    // Stop bit forced low
    clear_mon();
    send_byte(8'h00, 1'b0);
    repeat (300) @(negedge clk);
    chk("stop err", err_cnt, 1);
    chk("stop busy", busy, 1'b0);
    chk("stop rsp", rxq.size(), 0);

    // 4-cycle glitch on idle line
    clear_mon();
    uart_rxd = 1'b0;
    repeat (4) @(negedge clk);
    uart_rxd = 1'b1;
    repeat (300) @(negedge clk);
    chk("glitch err", err_cnt, 0);
    chk("glitch busy", busy, 1'b0);
    chk("glitch rsp", rxq.size() + we_cnt + re_cnt, 0);

    // Reset during a read response
    clear_mon();
    m_rd = 32'hDEADBEEF;
    for (int i = 0; i < 5; i++) send_byte(vt[1].bytes[71-8*i -: 8], 1'b1);
    lows = 0;
    for (int i = 0; i < 2000 && uart_txd; i++) @(negedge clk);
    chk("rr tx started", uart_txd, 1'b0);
    repeat (200) @(negedge clk);
    rstn = 1'b0;
    #1;
    chk("rr txd", uart_txd, 1'b1);
    chk("rr we", m_we, 1'b0);
    chk("rr re", m_re, 1'b0);
    chk("rr addr", m_addr, 32'h0);
    chk("rr wd", m_wd, 32'h0);
    chk("rr busy", busy, 1'b0);
    chk("rr ferr", frame_err, 1'b0);
    repeat (5) @(negedge clk);
    rstn = 1'b1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (!uart_txd) lows++;
    end
    chk("rr txd idle after", lows, 0);
    chk("rr busy after", busy, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
